// File: rtl/uart_cmd_fetch.sv
// uart_cmd_fetch: pops RX FIFO bytes, filters them against the command set and issues one-cycle pulses on oAscii.
// Optional build macro CMD_ECHO_EN echoes every issued command into the TX FIFO (skipped when iTx_Full).
module uart_cmd_fetch #(
  parameter int GAP_CYCLES = 2,
  parameter bit CASE_FOLD  = 1'b1,
  parameter int DROP_W     = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iRx_Empty,
  input  logic [7:0]        iRx_Data,
  output logic              oRx_Pop,
  output logic [7:0]        oAscii,
  output logic              oCmd_Valid,
  output logic [DROP_W-1:0] oDrop_Cnt,
  input  logic              iTx_Full,
  output logic              oTx_Push,
  output logic [7:0]        oTx_Data
);
  typedef enum logic [2:0] {IDLE, POP, WAIT, CHECK, ISSUE, GAP} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t            r_state, w_next;
  logic [7:0]        r_byte, r_ascii, w_fold, w_cbyte;
  logic              r_valid, w_is_cmd, w_is_ws;
  logic [DROP_W-1:0] r_drop;
  logic [3:0]        r_gap;
  always_comb begin
    w_fold   = (r_byte >= 8'h61 && r_byte <= 8'h7A) ? r_byte - 8'h20 : r_byte;
    w_cbyte  = CASE_FOLD ? w_fold : r_byte;
    w_is_cmd = w_cbyte inside {8'h43, 8'h57, 8'h54, 8'h55, 8'h44, 8'h4C, 8'h52, 8'h4D, 8'h53, 8'h58};
    w_is_ws  = w_cbyte inside {8'h0D, 8'h0A, 8'h20};
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = iRx_Empty ? IDLE : POP;
      POP:     w_next = WAIT;
      WAIT:    w_next = CHECK;
      CHECK:   w_next = w_is_cmd ? ISSUE : IDLE;
      ISSUE:   w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     w_next = (r_gap == GAP_LAST) ? IDLE : GAP;
      default: w_next = IDLE;
    endcase
  end
  // oAscii/oCmd_Valid are loaded on the CHECK->ISSUE edge so they are registered during ISSUE only
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_byte  <= 8'h00;
      r_ascii <= 8'h00;
      r_valid <= 1'b0;
      r_drop  <= '0;
      r_gap   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT) r_byte <= iRx_Data;
      r_ascii <= (r_state == CHECK && w_is_cmd) ? w_cbyte : 8'h00;
      r_valid <= r_state == CHECK && w_is_cmd;
      r_gap   <= (r_state == GAP) ? r_gap + 4'd1 : 4'd0;
      if (r_state == CHECK && !w_is_cmd && !w_is_ws && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end
  assign oRx_Pop    = r_state == POP;
  assign oAscii     = r_ascii;
  assign oCmd_Valid = r_valid;
  assign oDrop_Cnt  = r_drop;
`ifdef CMD_ECHO_EN
  assign oTx_Push = r_state == ISSUE && !iTx_Full;
  assign oTx_Data = oTx_Push ? r_ascii : 8'h00;
`else
  logic w_unused;
  assign w_unused = iTx_Full;
  assign oTx_Push = 1'b0;
  assign oTx_Data = 8'h00;
`endif
endmodule

// File: tb/tb_uart_cmd_fetch.sv
// tb_uart_cmd_fetch: random and directed stimulus against a transaction-level schedule model of uart_cmd_fetch.
module tb_uart_cmd_fetch;
  localparam int G = 2;
  logic       iClk = 0, iRst_n = 0, iRx_Empty = 1, iTx_Full = 0;
  logic [7:0] iRx_Data = 0;
  logic       oRx_Pop, oCmd_Valid, oTx_Push;
  logic [7:0] oAscii, oTx_Data, oDrop_Cnt;
  int         checks = 0, errors = 0, cyc = 0, n0, t0, p;
  logic [7:0] fq[$], mq[$], obs_a[$], obs_tx[$];
  int         obs_c[$];
  int         m_idle_at = 0, e_pop_at = -1, e_iss_at = -1, drop_at = -1;
  logic [7:0] e_iss = 0, m_drop = 0;
  bit         hold = 0;
  string      cmds = "CWTUDLRMSX";

  uart_cmd_fetch #(.GAP_CYCLES(G), .CASE_FOLD(1'b1), .DROP_W(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iRx_Empty(iRx_Empty), .iRx_Data(iRx_Data),
    .oRx_Pop(oRx_Pop), .oAscii(oAscii), .oCmd_Valid(oCmd_Valid), .oDrop_Cnt(oDrop_Cnt),
    .iTx_Full(iTx_Full), .oTx_Push(oTx_Push), .oTx_Data(oTx_Data));

  always #5 iClk = ~iClk;

  function automatic logic [7:0] fold(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction
  function automatic bit is_cmd(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (c == cmds[i]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit is_ws(input logic [7:0] c);
    return c == 8'h0D || c == 8'h0A || c == 8'h20;
  endfunction
  function automatic logic [7:0] rand_byte();
    int k = $urandom_range(0, 3);
    return k == 0 ? cmds[$urandom_range(0, 9)] :
           k == 1 ? 8'(8'h61 + $urandom_range(0, 25)) :
           k == 2 ? (($urandom_range(0, 2) == 0) ? 8'h0D : ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h20) :
           8'($urandom);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
    end
  endtask

  // FIFO emulation: data held through POP and WAIT, garbage otherwise
  task automatic tick();
    @(posedge iClk);
    #1;
    cyc++;
    if (oRx_Pop && fq.size() > 0) begin
      iRx_Data = fq.pop_front();
      hold = 1;
    end else if (hold) hold = 0;
    else iRx_Data = 8'($urandom);
    iRx_Empty = fq.size() == 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    mq.push_back(b);
    iRx_Empty = 0;
  endtask
  task automatic do_reset(input int n);
    iRst_n = 0;
    fq.delete();
    mq.delete();
    iRx_Empty = 1;
    ticks(n);
    iRst_n = 1;
  endtask

  // Schedule model: an accepted byte pops 1 cycle after the idle decision, issues at +4,
  // and the engine is free again at +5+G (command) or +4 (anything else).
  always @(negedge iClk) begin : cmp
    logic [7:0] c;
    logic       e_push;
    if (!iRst_n) begin
      m_idle_at = cyc + 1;
      e_pop_at  = -1;
      e_iss_at  = -1;
      drop_at   = -1;
      m_drop    = 0;
    end else begin
      if (cyc == drop_at) m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
      if (cyc >= m_idle_at && mq.size() > 0) begin
        c = fold(mq.pop_front());
        e_pop_at = cyc + 1;
        if (is_cmd(c)) begin
          e_iss_at  = cyc + 4;
          e_iss     = c;
          m_idle_at = cyc + 5 + G;
        end else begin
          m_idle_at = cyc + 4;
          if (!is_ws(c)) drop_at = cyc + 4;
        end
      end
    end
    chk("pop", oRx_Pop, cyc == e_pop_at);
    chk("ascii", oAscii, (cyc == e_iss_at) ? e_iss : 8'h00);
    chk("valid", oCmd_Valid, cyc == e_iss_at);
    chk("drop", oDrop_Cnt, m_drop);
`ifdef CMD_ECHO_EN
    e_push = cyc == e_iss_at && !iTx_Full;
`else
    e_push = 1'b0;
`endif
    chk("tx_push", oTx_Push, e_push);
    chk("tx_data", oTx_Data, e_push ? e_iss : 8'h00);
    if (oCmd_Valid) begin
      obs_a.push_back(oAscii);
      obs_c.push_back(cyc);
    end
    if (oTx_Push) obs_tx.push_back(oTx_Data);
  end

  initial begin
    ticks(2);
    push(8'h55);
    ticks(4);
    chk("rst_pop", oRx_Pop, 0);
    chk("rst_ascii", oAscii, 8'h00);
    chk("rst_drop", oDrop_Cnt, 8'h00);
    n0 = obs_a.size();
    p = cyc;
    iRst_n = 1;
    ticks(12);
    chk("u_count", obs_a.size() - n0, 1);
    chk("u_value", obs_a[n0], 8'h55);
    chk("u_latency", obs_c[n0] - p, 4);

    n0 = obs_a.size();
    p = cyc;
    push(8'h6D);
    push(8'h73);
    ticks(20);
    chk("ms_count", obs_a.size() - n0, 2);
    chk("ms_first", obs_a[n0], 8'h4D);
    chk("ms_second", obs_a[n0+1], 8'h53);
    chk("ms_latency", obs_c[n0] - p, 4);
    chk("ms_spacing", obs_c[n0+1] - obs_c[n0], 7);

    do_reset(2);
    n0 = obs_a.size();
    push(8'h41);
    push(8'h0D);
    push(8'h7E);
    ticks(16);
    chk("bad_drop", oDrop_Cnt, 8'd2);
    chk("bad_novalid", obs_a.size() - n0, 0);
    for (int i = 0; i < 256; i++) push(8'(8'h80 + $urandom_range(0, 127)));
    ticks(256 * 4 + 10);
    chk("drop_sat", oDrop_Cnt, 8'hFF);

    do_reset(2);
    n0 = obs_a.size();
    push(8'h53);
    ticks(3);
    iRst_n = 0;
    #1;
    chk("mid_rst_ascii", oAscii, 8'h00);
    ticks(2);
    iRst_n = 1;
    ticks(10);
    chk("mid_rst_nos", obs_a.size() - n0, 0);
    p = cyc;
    push(8'h43);
    ticks(10);
    chk("after_rst_count", obs_a.size() - n0, 1);
    chk("after_rst_value", obs_a[n0], 8'h43);
    chk("after_rst_latency", obs_c[n0] - p, 4);

`ifdef CMD_ECHO_EN
    n0 = obs_a.size();
    t0 = obs_tx.size();
    iTx_Full = 1;
    push(8'h58);
    ticks(12);
    iTx_Full = 0;
    push(8'h43);
    ticks(12);
    chk("echo_issued", obs_a.size() - n0, 2);
    chk("echo_x", obs_a[n0], 8'h58);
    chk("echo_pushes", obs_tx.size() - t0, 1);
    chk("echo_data", obs_tx[t0], 8'h43);
`endif

    do_reset(2);
    n0 = obs_a.size();
    for (int i = 0; i < 6000; i++) begin
      tick();
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0 && fq.size() < 8) push(rand_byte());
      iTx_Full = 1'($urandom_range(0, 1));
    end
    chk("random_activity", obs_a.size() > n0, 1);
    ticks(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
